// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
// State and display-select encodings are visible on the debug outputs.
package calc_pkg;

  localparam int OPC_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OP1    = 3'd1,
    ST_OPSEL  = 3'd2,
    ST_OP2    = 3'd3,
    ST_RESULT = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    DISP_BLANK  = 2'd0,
    DISP_ENTRY  = 2'd1,
    DISP_RESULT = 2'd2,
    DISP_ERR    = 2'd3
  } disp_sel_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// Key-event / ALU / display bundle between the calculator front end and
// the sequencer. master = key encoders and ALU side, slave = sequencer.
interface calc_sequencer_if;

  logic                     key_digit_vld;
  logic                     key_op_vld;
  logic [calc_pkg::OPC_W-1:0] key_op;
  logic                     key_enter;
  logic                     key_result;
  logic                     key_clear;
  logic                     alu_o_flag;

  logic                     store_dig;
  logic                     enter;
  logic                     result_ready;
  logic [calc_pkg::OPC_W-1:0] opcode;
  logic [1:0]               disp_sel;
  logic [1:0]               digit_cnt;
  logic                     err;
  logic [2:0]               state_o;

  modport master (
    output key_digit_vld, key_op_vld, key_op, key_enter, key_result,
           key_clear, alu_o_flag,
    input  store_dig, enter, result_ready, opcode, disp_sel, digit_cnt,
           err, state_o
  );

  modport slave (
    input  key_digit_vld, key_op_vld, key_op, key_enter, key_result,
           key_clear, alu_o_flag,
    output store_dig, enter, result_ready, opcode, disp_sel, digit_cnt,
           err, state_o
  );

endinterface

// File: rtl/idle_timer.sv
// Idle-cycle counter for the calculator auto-clear.
// Counts enabled cycles, clears on request, saturates at TIMEOUT_CYCLES-1
// and flags expiry while sitting at that value.
module idle_timer #(
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = TIMEOUT_CYCLES - ONE;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step until the terminal value and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator operation sequencer: operand-1 entry, operator select,
// operand-2 entry, result/error display, with idle auto-clear.
// Optional build macro CALC_CHAIN_EN: an operator key while a result is
// shown chains the result into the next operation as operand 1.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned      MAX_DIGITS     = 3,
  parameter int unsigned      CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic            hwclk,
  input  logic            reset,
  calc_sequencer_if.slave bus
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t           state_q, state_d;
  disp_sel_t        disp_sel_q, disp_sel_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic [1:0]       digit_cnt_q, digit_cnt_d;
  logic             err_q, err_d;
  logic             store_dig_q, store_dig_d;
  logic             enter_q, enter_d;
  logic             result_ready_q, result_ready_d;

  logic ev_clear, ev_result, ev_enter, ev_op, ev_digit;
  logic any_key;
  logic can_store;
  logic tmr_en, tmr_clr, tmr_expired, timeout;

  // Resolve simultaneous keys: clear > result > enter > op > digit.
  always_comb begin
    ev_clear  = bus.key_clear;
    ev_result = bus.key_result    & ~bus.key_clear;
    ev_enter  = bus.key_enter     & ~bus.key_clear & ~bus.key_result;
    ev_op     = bus.key_op_vld    & ~bus.key_clear & ~bus.key_result
                                  & ~bus.key_enter;
    ev_digit  = bus.key_digit_vld & ~bus.key_clear & ~bus.key_result
                                  & ~bus.key_enter & ~bus.key_op_vld;
    any_key   = bus.key_clear | bus.key_result | bus.key_enter
              | bus.key_op_vld | bus.key_digit_vld;
  end

  // The timer only runs while an operation is in progress and no key is
  // pressed; sitting in IDLE keeps it parked at zero so a stale expiry can
  // never swallow the first key of the next operation.
  assign tmr_en  = (state_q != ST_IDLE) && !any_key;
  assign tmr_clr = any_key || (state_q == ST_IDLE);
  assign timeout = tmr_expired && tmr_en;

  idle_timer #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_i     (hwclk),
    .rst_i     (reset),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  assign can_store = (digit_cnt_q < MAX_CNT);

  // Next-state and registered-strobe decode for the winning event.
  always_comb begin
    state_d        = state_q;
    disp_sel_d     = disp_sel_q;
    opcode_d       = opcode_q;
    digit_cnt_d    = digit_cnt_q;
    err_d          = err_q;
    store_dig_d    = 1'b0;
    enter_d        = 1'b0;
    result_ready_d = 1'b0;

    if (ev_clear || timeout) begin
      // Clear and idle timeout both abandon the operation; opcode survives.
      state_d     = ST_IDLE;
      disp_sel_d  = DISP_BLANK;
      digit_cnt_d = 2'd0;
      err_d       = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ev_digit) begin
            store_dig_d = 1'b1;
            digit_cnt_d = 2'd1;
            disp_sel_d  = DISP_ENTRY;
            state_d     = ST_OP1;
          end
        end

        ST_OP1: begin
          if (ev_op) begin
            opcode_d = bus.key_op;
            state_d  = ST_OPSEL;
          end else if (ev_digit && can_store) begin
            store_dig_d = 1'b1;
            digit_cnt_d = digit_cnt_q + 2'd1;
          end
        end

        ST_OPSEL: begin
          if (ev_enter) begin
            enter_d     = 1'b1;
            digit_cnt_d = 2'd0;
            state_d     = ST_OP2;
          end else if (ev_op) begin
            opcode_d = bus.key_op;
          end
        end

        ST_OP2: begin
          if (ev_result && (digit_cnt_q != 2'd0)) begin
            // Overflow is sampled in the result-key cycle itself.
            if (bus.alu_o_flag) begin
              err_d      = 1'b1;
              disp_sel_d = DISP_ERR;
              state_d    = ST_ERROR;
            end else begin
              result_ready_d = 1'b1;
              disp_sel_d     = DISP_RESULT;
              state_d        = ST_RESULT;
            end
          end else if (ev_digit && can_store) begin
            store_dig_d = 1'b1;
            digit_cnt_d = digit_cnt_q + 2'd1;
          end
        end

        ST_RESULT: begin
`ifdef CALC_CHAIN_EN
          if (ev_op) begin
            // Displayed result becomes operand 1 of the next operation.
            opcode_d    = bus.key_op;
            enter_d     = 1'b1;
            digit_cnt_d = 2'd0;
            disp_sel_d  = DISP_ENTRY;
            state_d     = ST_OP2;
          end else if (ev_digit) begin
            store_dig_d = 1'b1;
            digit_cnt_d = 2'd1;
            disp_sel_d  = DISP_ENTRY;
            state_d     = ST_OP1;
          end
`else
          if (ev_digit) begin
            store_dig_d = 1'b1;
            digit_cnt_d = 2'd1;
            disp_sel_d  = DISP_ENTRY;
            state_d     = ST_OP1;
          end
`endif
        end

        ST_ERROR: begin
          // Only clear or timeout (handled above) leave the error state.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, status and strobe registers.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      disp_sel_q     <= DISP_BLANK;
      opcode_q       <= '0;
      digit_cnt_q    <= 2'd0;
      err_q          <= 1'b0;
      store_dig_q    <= 1'b0;
      enter_q        <= 1'b0;
      result_ready_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      disp_sel_q     <= disp_sel_d;
      opcode_q       <= opcode_d;
      digit_cnt_q    <= digit_cnt_d;
      err_q          <= err_d;
      store_dig_q    <= store_dig_d;
      enter_q        <= enter_d;
      result_ready_q <= result_ready_d;
    end
  end

  assign bus.store_dig    = store_dig_q;
  assign bus.enter        = enter_q;
  assign bus.result_ready = result_ready_q;
  assign bus.opcode       = opcode_q;
  assign bus.disp_sel     = disp_sel_q;
  assign bus.digit_cnt    = digit_cnt_q;
  assign bus.err          = err_q;
  assign bus.state_o      = state_q;

endmodule
